pattern_generator: RTL

Builds a new random Memory Matrix board each round: on a start request it clears the board and lights exactly `num_tiles` distinct cells, chosen by a free-running LFSR. It sits between the round controller and the guess checker, and is the writer of the board vector that the checker reads. A collision-probe rule bounds generation time, so `done` always arrives.

---
 rtl/memory_matrix_pkg.sv | 20 ++
 rtl/lfsr16.sv | 21 ++
 rtl/pattern_generator.sv | 119 +++++++++++
 3 files changed

// File: rtl/memory_matrix_pkg.sv
// Shared constants and types for the Memory Matrix game blocks: board geometry,
// tile clamp, pattern-generator FSM states and the LFSR definition.
package memory_matrix_pkg;

  localparam int CELLS     = 16;
  localparam int IDX_W     = 4;
  localparam int MAX_TILES = 8;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } pg_state_t;

  localparam int              LFSR_W    = 16;
  // Right-shifting Fibonacci form of taps 16,14,13,11: feedback from bits 0,2,3,5.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; steps every clock once reset is released.
module lfsr16
  import memory_matrix_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] q
);

  // New bit enters at the top; the tap parity comes from the low end.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= SEED;
    end else begin
      q <= {^(q & LFSR_TAPS), q[15:1]};
    end
  end

endmodule

// File: rtl/pattern_generator.sv
// Builds a fresh random board per round: clears it, then lights target distinct
// cells, probing linearly past collisions so every round terminates.
module pattern_generator
  import memory_matrix_pkg::*;
#(
  parameter int          CELLS     = memory_matrix_pkg::CELLS,
  parameter int          IDX_W     = memory_matrix_pkg::IDX_W,
  parameter int          MAX_TILES = memory_matrix_pkg::MAX_TILES,
  parameter logic [15:0] SEED      = memory_matrix_pkg::LFSR_SEED
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [IDX_W-1:0] num_tiles,
  output logic             busy,
  output logic             done,
  output logic [CELLS-1:0] board,
  output logic [IDX_W:0]   tiles_placed
);

  localparam int               CNT_W    = IDX_W + 1;
  localparam logic [CNT_W-1:0] TILE_CAP = CNT_W'(MAX_TILES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  pg_state_t        state;
  pg_state_t        state_next;
  logic [CELLS-1:0] board_next;
  logic [CNT_W-1:0] tiles_next;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] target_next;
  logic [CNT_W-1:0] req_tiles;
  logic             collided;
  logic             collided_next;
  logic [IDX_W-1:0] probe_ptr;
  logic [IDX_W-1:0] probe_next;
  logic [IDX_W-1:0] cand;
  logic [15:0]      lfsr_q;
  logic             lfsr_unused;

  lfsr16 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr_q)
  );

  // Only the low index bits pick a cell; the rest just keep the sequence long.
  assign lfsr_unused = ^lfsr_q[15:IDX_W];

  assign busy = (state == FILL);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      board        <= '0;
      tiles_placed <= '0;
      target       <= '0;
      collided     <= 1'b0;
      probe_ptr    <= '0;
    end else begin
      state        <= state_next;
      board        <= board_next;
      tiles_placed <= tiles_next;
      target       <= target_next;
      collided     <= collided_next;
      probe_ptr    <= probe_next;
    end
  end

  // After a collision the next candidates walk upward from the lit cell,
  // so a free cell is reached within CELLS-1 steps while target < CELLS.
  always_comb begin
    state_next    = state;
    board_next    = board;
    tiles_next    = tiles_placed;
    target_next   = target;
    collided_next = collided;
    probe_next    = probe_ptr;
    req_tiles     = {1'b0, num_tiles};
    cand          = collided ? probe_ptr : lfsr_q[IDX_W-1:0];

    case (state)
      IDLE: begin
        if (start) begin
          board_next    = '0;
          tiles_next    = '0;
          target_next   = (req_tiles > TILE_CAP) ? TILE_CAP : req_tiles;
          collided_next = 1'b0;
          state_next    = FILL;
        end
      end
      FILL: begin
        if (tiles_placed == target) begin
          state_next = DONE;
        end else if (!board[cand]) begin
          board_next[cand] = 1'b1;
          tiles_next       = tiles_placed + CNT_ONE;
          collided_next    = 1'b0;
          if (tiles_next == target) begin
            state_next = DONE;
          end
        end else begin
          collided_next = 1'b1;
          probe_next    = cand + IDX_ONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
